// File: rtl/display_pkg.sv
// display_pkg: shared types, state encoding and BCD-to-7-segment decode for the display scanner.
`default_nettype none
package display_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Segment order {a,b,c,d,e,f,g}; non-decimal nibbles show nothing.
  function automatic seg7_t bcd_to_seg7(input logic [3:0] nibble);
    case (nibble)
      4'd0:    bcd_to_seg7 = 7'b1111110;
      4'd1:    bcd_to_seg7 = 7'b0110000;
      4'd2:    bcd_to_seg7 = 7'b1101101;
      4'd3:    bcd_to_seg7 = 7'b1111001;
      4'd4:    bcd_to_seg7 = 7'b0110011;
      4'd5:    bcd_to_seg7 = 7'b1011011;
      4'd6:    bcd_to_seg7 = 7'b1011111;
      4'd7:    bcd_to_seg7 = 7'b1110000;
      4'd8:    bcd_to_seg7 = 7'b1111111;
      4'd9:    bcd_to_seg7 = 7'b1110011;
      default: bcd_to_seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_seg7_encoder.sv
// display_seg7_encoder: combinational nibble + blank flag to active-high segment pattern.
`default_nettype none
module display_seg7_encoder
  import display_pkg::*;
(
  input  logic       [3:0] nibble,
  input  logic             blank,
  output logic       [6:0] seg
);

  assign seg = blank ? SEG_BLANK : bcd_to_seg7(nibble);

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
// display_scan_controller: N-digit multiplexed 7-segment scanner, double-buffered BCD input, anti-ghost gap.
// Define DISPLAY_LZ_BLANK_EN to blank leading zeros (mask captured when a new word is swapped in).
`default_nettype none
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 10000,
  parameter int GAP_CYCLES     = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    bcd_valid,
  input  logic [4*NUM_DIGITS-1:0] bcd_code,
  output logic                    bcd_ready,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   display_select,
  output logic                    frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      ON_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_POL  = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  scan_state_e             state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt, idx_inc;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    last_digit, boundary;
  logic [4*NUM_DIGITS-1:0] disp, disp_nxt, pending;
  logic                    pend_full, pend_full_nxt, ready_q;
  logic                    accept, swap, blank_bit;
  logic [6:0]              seg_raw, seg_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  assign last_digit = (idx == IDX_LAST);
  assign idx_inc    = last_digit ? '0 : idx + IDX_W'(1);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    boundary  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ON;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        ON: begin
          if (cnt == ON_LAST) begin
            cnt_nxt = '0;
            if (GAP_CYCLES > 0) begin
              state_nxt = GAP;
            end else begin
              idx_nxt  = idx_inc;
              boundary = last_digit;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = ON;
            cnt_nxt   = '0;
            idx_nxt   = idx_inc;
            boundary  = last_digit;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ready mirrors an empty pending slot, so accept and swap can never coincide.
  assign accept = bcd_valid && ready_q;
  assign swap   = pend_full && (boundary || (state == IDLE));

  always_comb begin
    pend_full_nxt = pend_full;
    if (accept)    pend_full_nxt = 1'b1;
    else if (swap) pend_full_nxt = 1'b0;
  end

  assign disp_nxt = swap ? pending : disp;

`ifdef DISPLAY_LZ_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] LZ_RESET_MASK = ~(NUM_DIGITS'(1));

  logic [NUM_DIGITS-1:0] mask, mask_nxt;

  // Digit 0 is never blanked, so a zero word still shows a single 0.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] code);
    logic lead;
    lz_mask = '0;
    lead    = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (code[4*i +: 4] != 4'd0) lead = 1'b0;
      lz_mask[i] = lead;
    end
  endfunction

  assign mask_nxt  = swap ? lz_mask(pending) : mask;
  assign blank_bit = mask_nxt[idx_nxt];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mask <= LZ_RESET_MASK;
    else          mask <= mask_nxt;
  end
`else
  assign blank_bit = 1'b0;
`endif

  display_seg7_encoder u_encoder (
    .nibble (disp_nxt[{idx_nxt, 2'b00} +: 4]),
    .blank  (blank_bit),
    .seg    (seg_raw)
  );

  // Outputs are registered from next-state values so they move together with state/index.
  assign seg_nxt = (state_nxt == ON) ? seg_raw : SEG_BLANK;
  assign sel_nxt = (state_nxt == ON) ? (NUM_DIGITS'(1) << idx_nxt) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      disp           <= '0;
      pending        <= '0;
      pend_full      <= 1'b0;
      ready_q        <= 1'b1;
      segments       <= SEG_BLANK ^ SEG_POL;
      display_select <= SEL_POL;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      disp           <= disp_nxt;
      if (accept) pending <= bcd_code;
      pend_full      <= pend_full_nxt;
      ready_q        <= ~pend_full_nxt;
      segments       <= seg_nxt ^ SEG_POL;
      display_select <= sel_nxt ^ SEL_POL;
      frame_done     <= boundary;
    end
  end

  assign bcd_ready = ready_q;

endmodule
`default_nettype wire
